// File: rtl/seq_bin2bcd_pkg.sv
// Shared types, segment codes and helpers for the sequential binary-to-BCD converter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Segment codes, bit order {a,b,c,d,e,f,g}, active-high
  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Double-dabble correction: a digit >= 5 gets +3 so the following shift carries correctly
  function automatic logic [3:0] add3_fix(input logic [3:0] d);
    return (d >= 4'd5) ? (d + 4'd3) : d;
  endfunction

  // Elaboration-time helper for the digit-capacity check
  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_to_7sd.sv
// Combinational BCD digit to 7-segment encoder, abcdefg active-high; codes > 9 blank.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module bcd_digit_to_7sd
  import seq_bin2bcd_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Lookup of the segment pattern for one decimal digit
  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seq_bin2bcd_7sd.sv
// Iterative double-dabble binary-to-BCD converter (one bit per clock) with 7-segment outputs.
// Latency: WIDTH cycles from input accept to OUT_VALID; one result per WIDTH+2 cycles.
// Backpressure: result held in DONE until OUT_READY; IN_READY low outside IDLE.
// Optional: define SEQ_BIN2BCD_LEADING_ZERO_BLANK_EN to blank leading-zero digits on SEG_OUT.
module seq_bin2bcd_7sd
  import seq_bin2bcd_pkg::*;
#(
  parameter int WIDTH  = 9,
  parameter int DIGITS = 3
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [WIDTH-1:0]      BIN_IN,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [4*DIGITS-1:0]   BCD_OUT,
  output logic [7*DIGITS-1:0]   SEG_OUT,
  output logic                  BUSY
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;
  localparam longint unsigned MAX_IN = (64'd1 << WIDTH) - 64'd1;

  // The digit count must be able to represent the largest input value
  if (pow10(DIGITS) <= MAX_IN) begin : g_digits_check
    $error("seq_bin2bcd_7sd: DIGITS too small for WIDTH");
  end

  state_t               state;
  state_t               state_nxt;
  logic [WIDTH-1:0]     shift_q;
  logic [BW-1:0]        scratch_q;
  logic [CW-1:0]        cnt_q;
  logic [BW-1:0]        corrected;
  logic [BW-1:0]        scratch_nxt;
  logic [7*DIGITS-1:0]  seg_nxt;
  logic                 load;
  logic                 step;
  logic                 last;

  // Per-digit add-3 correction, no carry between digits
  for (genvar i = 0; i < DIGITS; i++) begin : g_fix
    assign corrected[4*i +: 4] = add3_fix(scratch_q[4*i +: 4]);
  end

  // The scratch picks up the next binary MSB on each shift
  assign scratch_nxt = {corrected[BW-2:0], shift_q[WIDTH-1]};
  assign last        = (cnt_q == CW'(1));

`ifdef SEQ_BIN2BCD_LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] blank;
  logic              seen_nz;

  // Mark digits above the most significant non-zero digit; digit 0 always shows
  always_comb begin
    blank   = '0;
    seen_nz = 1'b0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      seen_nz  = seen_nz | (scratch_nxt[4*i +: 4] != 4'd0);
      blank[i] = !seen_nz;
    end
  end
`endif

  // Segment encoding of the final scratch, registered together with BCD_OUT
  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    logic [6:0] seg_raw;

    bcd_digit_to_7sd u_enc (
      .bcd (scratch_nxt[4*i +: 4]),
      .seg (seg_raw)
    );

`ifdef SEQ_BIN2BCD_LEADING_ZERO_BLANK_EN
    assign seg_nxt[7*i +: 7] = blank[i] ? SEG_BLANK : seg_raw;
`else
    assign seg_nxt[7*i +: 7] = seg_raw;
`endif
  end

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nxt = state;
    IN_READY  = 1'b0;
    OUT_VALID = 1'b0;
    BUSY      = 1'b0;
    load      = 1'b0;
    step      = 1'b0;
    unique case (state)
      IDLE: begin
        IN_READY = 1'b1;
        if (IN_VALID) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        BUSY = 1'b1;
        step = 1'b1;
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        OUT_VALID = 1'b1;
        if (OUT_READY) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Shift/scratch/counter datapath; results latch on the final shift and persist afterwards
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      BCD_OUT   <= '0;
      SEG_OUT   <= '0;
    end else if (load) begin
      shift_q   <= BIN_IN;
      scratch_q <= '0;
      cnt_q     <= CW'(WIDTH);
    end else if (step) begin
      shift_q   <= shift_q << 1;
      scratch_q <= scratch_nxt;
      cnt_q     <= cnt_q - CW'(1);
      if (last) begin
        BCD_OUT <= scratch_nxt;
        SEG_OUT <= seg_nxt;
      end
    end
  end

endmodule

// File: tb/tb_seq_bin2bcd_7sd.sv
// Scoreboard bench for seq_bin2bcd_7sd at default parameters (WIDTH=9, DIGITS=3).
// Latency: checks OUT_VALID rises exactly WIDTH edges after accept.
// Backpressure: exercises OUT_READY stalls and IN_VALID while busy.
module tb_seq_bin2bcd_7sd;

  localparam int WIDTH  = 9;
  localparam int DIGITS = 3;

  typedef struct {
    logic [11:0] bcd;
    logic [20:0] seg;
  } exp_t;

  logic        CLK;
  logic        RST_N;
  logic        IN_VALID;
  logic        IN_READY;
  logic [8:0]  BIN_IN;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [11:0] BCD_OUT;
  logic [20:0] SEG_OUT;
  logic        BUSY;

  int   checks;
  int   errors;
  int   cyc;
  int   acc_edge;
  logic prev_ov;
  exp_t exp_q[$];
  exp_t hold_e;

  seq_bin2bcd_7sd #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .BIN_IN    (BIN_IN),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .BCD_OUT   (BCD_OUT),
    .SEG_OUT   (SEG_OUT),
    .BUSY      (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg7(input int d);
    case (d)
      0: return 7'b1111110;
      1: return 7'b0110000;
      2: return 7'b1101101;
      3: return 7'b1111001;
      4: return 7'b0110011;
      5: return 7'b1011011;
      6: return 7'b1011111;
      7: return 7'b1110000;
      8: return 7'b1111111;
      9: return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic exp_t model(input int v);
    exp_t       e;
    int         d[3];
    logic [6:0] s[3];
    d[0] = v % 10;
    d[1] = (v / 10) % 10;
    d[2] = (v / 100) % 10;
    for (int i = 0; i < 3; i++) begin
      s[i] = seg7(d[i]);
      e.bcd[4*i +: 4] = 4'(d[i]);
    end
`ifdef SEQ_BIN2BCD_LEADING_ZERO_BLANK_EN
    if (d[2] == 0) s[2] = 7'b0000000;
    if (d[2] == 0 && d[1] == 0) s[1] = 7'b0000000;
`endif
    e.seg = {s[2], s[1], s[0]};
    return e;
  endfunction

  // One clock: record accepts / compare results on handshakes, then advance past the edge
  task automatic tick();
    exp_t e;
    if (RST_N && IN_VALID && IN_READY) begin
      exp_q.push_back(model(int'(BIN_IN)));
      acc_edge = cyc + 1;
    end
    if (RST_N && OUT_VALID && OUT_READY) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("bcd", 64'(BCD_OUT), 64'(e.bcd));
        check("seg", 64'(SEG_OUT), 64'(e.seg));
      end
    end
    @(posedge CLK);
    #1;
    cyc++;
    if (OUT_VALID && !prev_ov) check("latency", 64'(cyc - acc_edge), 64'(WIDTH));
    prev_ov = OUT_VALID;
  endtask

  task automatic send(input int v);
    BIN_IN   = 9'(v);
    IN_VALID = 1'b1;
    for (int n = 0; n < 100 && !IN_READY; n++) tick();
    check("accept_ready", 64'(IN_READY), 64'd1);
    tick();
    IN_VALID = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && exp_q.size() != 0; n++) tick();
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    acc_edge  = 0;
    prev_ov   = 1'b0;
    RST_N     = 1'b0;
    IN_VALID  = 1'b1;
    BIN_IN    = 9'd123;
    OUT_READY = 1'b1;

    // Reset held with IN_VALID asserted: nothing may start
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rst_busy", 64'(BUSY), 64'd0);
      check("rst_ov", 64'(OUT_VALID), 64'd0);
    end
    RST_N    = 1'b1;
    IN_VALID = 1'b0;
    #1;
    check("rel_in_ready", 64'(IN_READY), 64'd1);
    check("rel_ov", 64'(OUT_VALID), 64'd0);
    check("rel_busy", 64'(BUSY), 64'd0);
    check("rel_bcd", 64'(BCD_OUT), 64'd0);
    check("rel_seg", 64'(SEG_OUT), 64'd0);
    tick();

    // 255 through the full pipe
    send(255);
    check("shift_busy", 64'(BUSY), 64'd1);
    check("shift_in_ready", 64'(IN_READY), 64'd0);
    drain();
    check("ready_after_255", 64'(IN_READY), 64'd1);
    check("bcd_255", 64'(BCD_OUT), 64'h255);
    check("seg_255", 64'(SEG_OUT), 64'({7'b1101101, 7'b1011011, 7'b1011011}));

    // Extremes
    send(511);
    drain();
    check("bcd_511", 64'(BCD_OUT), 64'h511);
    send(0);
    drain();
    check("bcd_0", 64'(BCD_OUT), 64'h000);
`ifdef SEQ_BIN2BCD_LEADING_ZERO_BLANK_EN
    check("seg_0", 64'(SEG_OUT), 64'({7'b0000000, 7'b0000000, 7'b1111110}));
`else
    check("seg_0", 64'(SEG_OUT), 64'({7'b1111110, 7'b1111110, 7'b1111110}));
`endif

    // Backpressure in DONE while IN_VALID toggles
    OUT_READY = 1'b0;
    send(200);
    for (int n = 0; n < 50 && !OUT_VALID; n++) tick();
    hold_e = model(200);
    for (int k = 0; k < 6; k++) begin
      IN_VALID = k[0];
      BIN_IN   = 9'd99;
      check("hold_ov", 64'(OUT_VALID), 64'd1);
      check("hold_in_ready", 64'(IN_READY), 64'd0);
      check("hold_bcd", 64'(BCD_OUT), 64'(hold_e.bcd));
      check("hold_seg", 64'(SEG_OUT), 64'(hold_e.seg));
      tick();
    end
    OUT_READY = 1'b1;
    IN_VALID  = 1'b1;
    tick();
    check("idle_after_hs", 64'(IN_READY), 64'd1);
    check("ov_drop", 64'(OUT_VALID), 64'd0);
    tick();
    IN_VALID = 1'b0;
    drain();
    check("bcd_99", 64'(BCD_OUT), 64'h099);

    // Reset in the middle of SHIFT
    send(300);
    for (int k = 0; k < 4; k++) tick();
    RST_N = 1'b0;
    #1;
    check("mid_rst_busy", 64'(BUSY), 64'd0);
    check("mid_rst_ov", 64'(OUT_VALID), 64'd0);
    check("mid_rst_ready", 64'(IN_READY), 64'd1);
    check("mid_rst_bcd", 64'(BCD_OUT), 64'd0);
    check("mid_rst_seg", 64'(SEG_OUT), 64'd0);
    exp_q.delete();
    prev_ov = 1'b0;
    tick();
    tick();
    RST_N = 1'b1;
    tick();
    send(42);
    drain();
    check("bcd_42", 64'(BCD_OUT), 64'h042);
    for (int k = 0; k < 12; k++) tick();
    check("no_extra_result", 64'(OUT_VALID), 64'd0);

`ifdef SEQ_BIN2BCD_LEADING_ZERO_BLANK_EN
    send(7);
    drain();
    check("blank_7", 64'(SEG_OUT), 64'({7'b0000000, 7'b0000000, 7'b1110000}));
    send(0);
    drain();
    check("blank_0", 64'(SEG_OUT), 64'({7'b0000000, 7'b0000000, 7'b1111110}));
    send(105);
    drain();
    check("blank_105", 64'(SEG_OUT), 64'({7'b0110000, 7'b1111110, 7'b1011011}));
`endif

    // Random values, back-to-back with occasional stalls
    for (int k = 0; k < 12; k++) begin
      OUT_READY = 1'($urandom_range(0, 1));
      send(int'($urandom_range(0, 511)));
      for (int n = 0; n < 30 && !OUT_VALID; n++) tick();
      OUT_READY = 1'b1;
      drain();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_bin2bcd_7sd.md
Name: seq_bin2bcd_7sd

Overview:
Parametrised, multi-cycle binary-to-BCD converter with per-digit 7-segment encoding. Uses iterative double-dabble (shift-and-add-3), one bit per clock, instead of a combinational BCD tree, so it scales to wide adder results. Sits after the N-bit adder (sum plus carry-out) and drives the display digits through valid/ready handshakes on both sides.

Parameters:
WIDTH, 9, binary input width (default covers an 8-bit sum plus carry-out, max 511).
DIGITS, 3, number of BCD/7-segment digits. Must satisfy 10**DIGITS > 2**WIDTH-1. Elaboration-time assertion fails otherwise.

Ports:
CLK  in  1  rising-edge clock
RST_N  in  1  asynchronous active-low reset
IN_VALID  in  1  BIN_IN valid
IN_READY  out  1  converter can accept BIN_IN
BIN_IN  in  WIDTH  unsigned binary value
OUT_VALID  out  1  BCD_OUT/SEG_OUT hold a new result
OUT_READY  in  1  consumer accepts result
BCD_OUT  out  4*DIGITS  packed BCD, digit 0 (ones) in [3:0]
SEG_OUT  out  7*DIGITS  per digit [6:0]=a,b,c,d,e,f,g, active-high, digit 0 in [6:0]
BUSY  out  1  conversion in progress (state SHIFT)

Behaviour:
- Reset (async assert, sync-release use): state=IDLE; IN_READY=1 after reset release; OUT_VALID=0; BUSY=0; BCD_OUT=0; SEG_OUT=0 (all segments off); internal shift, scratch and counter registers = 0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - IN_READY=1.
  - On IN_VALID: capture BIN_IN, clear BCD scratch, load counter=WIDTH, go to SHIFT.
- SHIFT:
  - IN_READY=0, BUSY=1.
  - Each cycle: every scratch digit >=5 gets +3 (4-bit, no carry between digits), then {scratch, shift} shifts left by 1; counter decrements.
  - When the counter reaches 1, the last shift happens, BCD_OUT/SEG_OUT are registered from the final scratch, and the state goes to DONE.
- DONE:
  - OUT_VALID=1.
  - BCD_OUT/SEG_OUT held stable while OUT_READY=0.
  - On OUT_VALID&&OUT_READY: go to IDLE and OUT_VALID drops next cycle. BCD_OUT/SEG_OUT keep the last result (not cleared).
- Latency: input accepted at edge 0, OUT_VALID high after edge WIDTH (WIDTH cycles in SHIFT). Next accept is possible the cycle after the output handshake. Throughput is one result per WIDTH+2 cycles with OUT_READY=1.
- IN_VALID is ignored outside IDLE. BIN_IN only needs to be stable at the accept edge.
- Segment map, abcdefg:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
  - Codes >9 cannot occur. The encoder maps them to 0000000 anyway.
- Boundaries:
  - BIN_IN=0 gives all-zero BCD.
  - BIN_IN=2**WIDTH-1 gives the correct max with no overflow, guaranteed by the DIGITS constraint.
- Reset mid-operation (any state): immediate return to reset values. No result is produced for the aborted input.

Optional Feature:
- Macro: SEQ_BIN2BCD_LEADING_ZERO_BLANK_EN.
- Defined: SEG_OUT digits above the most significant non-zero digit are forced to 0000000. Digit 0 is never blanked, so value 0 shows a single "0". BCD_OUT is unaffected.
- Undefined: every digit is encoded, so leading zeros display as "0".

Decomposition:
- Package seq_bin2bcd_pkg:
  - state enum typedef (IDLE/SHIFT/DONE)
  - 7-bit segment constants SEG_0..SEG_9 and SEG_BLANK
  - function for the add-3 correction of a 4-bit digit
- Sub-module bcd_digit_to_7sd: combinational 4-bit BCD to 7-bit segment encoder, instantiated DIGITS times via generate.

Test Plan:
1. Reset: hold RST_N=0 for 3 cycles with IN_VALID=1 -> after release IN_READY=1, OUT_VALID=0, BUSY=0, BCD_OUT=0, SEG_OUT=0. No conversion while in reset.
2. BIN_IN=255 with OUT_READY=1 -> OUT_VALID high after 9 cycles, BCD_OUT=12'h255, SEG_OUT={1101101,1011011,1011011}. IN_READY high again 2 cycles after accept+9.
3. Extremes: BIN_IN=511 -> BCD_OUT=12'h511. Then BIN_IN=0 -> BCD_OUT=12'h000 and SEG_OUT={1111110,1111110,1111110} (macro undefined).
4. Backpressure: OUT_READY=0 for 6 cycles in DONE while IN_VALID toggles with BIN_IN=99 -> outputs stable at previous result, IN_READY=0. After OUT_READY=1 the 99 is only accepted in IDLE and yields 12'h099.
5. Reset mid-SHIFT: assert RST_N=0 at cycle 4 of converting 300 -> outputs return to reset values immediately. Then converting 42 yields 12'h042 with no residue.
6. With SEQ_BIN2BCD_LEADING_ZERO_BLANK_EN: BIN_IN=7 -> SEG_OUT={0000000,0000000,1110000}. BIN_IN=0 -> {0000000,0000000,1111110}. BIN_IN=105 -> {0110000,1111110,1011011}.
